tcdm_mp_responder: RTL and testbench
====================================

// Module: tcdm_mp_responder
// PURPOSE
// - TCDM-side responder for N_PORT XBAR_TCDM_BUS masters, e.g. the 4 HWPE streamer ports.
// - Round-robin arbitrates the port requests onto one single-port word memory.
// - Grants one request per cycle; returns r_valid/r_rdata on the granted port one cycle later.
// - Used standalone as a private accelerator scratchpad and as the slave model in HWPE benches.
// PARAMETERS
// N_PORT     4            number of TCDM master ports served (>=1)
// MEM_WORDS  1024         memory depth in 32-bit words (power of 2)
// BASE_ADDR  32'h1C01_0000 byte base address of the memory window (MEM_WORDS*4 aligned)
// ERR_RDATA  32'hBADA_CCE5 read data returned for out-of-window accesses
// PORTS
// clk_i           in   1            clock
// rst_ni          in   1            asynchronous active-low reset
// tcdm_req_i      in   N_PORT       request per port
// tcdm_gnt_o      out  N_PORT       grant per port; combinational, at most one bit set
// tcdm_add_i      in   N_PORT x 32  byte address; bits [1:0] ignored
// tcdm_wen_i      in   N_PORT       0 = write, 1 = read
// tcdm_be_i       in   N_PORT x 4   byte enables, writes only
// tcdm_wdata_i    in   N_PORT x 32  write data
// tcdm_r_rdata_o  out  N_PORT x 32  response data
// tcdm_r_valid_o  out  N_PORT       response valid, one-cycle pulse
// err_o           out  1            one-cycle pulse, registered with the erroneous response
// err_cnt_o       out  16           saturating count of out-of-window accesses
// BEHAVIOUR
// - Reset values: tcdm_r_valid_o=0, tcdm_r_rdata_o=0, err_o=0, err_cnt_o=0, rr_q=0.
// - Memory contents are not reset.
// - Arbitration:
//   - Scan ports starting at rr_q, upward, mod N_PORT; first requester p is granted, gnt[p]=1 in the same cycle.
//   - On a grant: rr_q <= (p+1) mod N_PORT. With no request, rr_q holds.
//   - Ungranted masters keep req/add/wen/be/wdata stable until granted.
// - Access (cycle T, grant to port p):
//   - off = add - BASE_ADDR; in-window iff add >= BASE_ADDR and off < 4*MEM_WORDS; word = off[log2(MEM_WORDS)+1:2].
//   - Write: bytes with be[i]=1 updated at the T edge; be=4'b0000 writes nothing.
//   - Read: memory word as of before the T edge.
// - Response (cycle T+1): r_valid_o[p]=1, all other r_valid bits 0.
//   - r_rdata_o[p] = read data, 32'h0 for a write, ERR_RDATA for out-of-window.
//   - r_rdata_o of non-responding ports holds its last value.
// - Latency and throughput:
//   - Grant-to-response latency is exactly 1 cycle, for reads and writes.
//   - Sustains 1 access/cycle; back-to-back grants to the same port allowed when it is the only requester.
// - Out-of-window access: granted normally, no memory update, err_o=1 in T+1, err_cnt_o += 1, saturating at 16'hFFFF.
// - Ordering: a read granted in T+1 to the word written in T returns the written data.
// - Starvation bound: a held request is granted within N_PORT cycles.
// - Reset asserted mid-operation:
//   - Outputs and rr_q clear asynchronously; a pending response is dropped.
//   - tcdm_gnt_o is forced 0 while rst_ni=0.
// TESTING
// - Single port: write 0xA5A5_1234 to BASE+0x10 with be=4'hF, read it back.
//   -> gnt same cycle; r_valid at T+1 with rdata 0; read returns 0xA5A5_1234 one cycle after its grant.
// - Byte enables: word=0xFFFF_FFFF, write 0x0000_0000 with be=4'b0101.
//   -> readback 0xFF00_FF00; be=0 write leaves word unchanged.
// - Contention: all 4 ports request every cycle from reset.
//   -> grants in order 0,1,2,3,0,... one per cycle; each response on the matching port one cycle later.
// - Out of window: read at BASE+4*MEM_WORDS and at BASE-4.
//   -> both granted, rdata 0xBADA_CCE5, err_o pulses twice, err_cnt_o=2, memory unchanged.
// - Saturation: force 65537 error accesses -> err_cnt_o stops at 16'hFFFF.
// - Reset mid-operation: assert rst_ni low in the cycle after a read grant.
//   -> r_valid_o=0 immediately; after release, first grant goes to port 0; previously written data still reads back.

Source files
------------

// File: rtl/tcdm_mp_responder.sv
// Multi-port TCDM responder: round-robin arbitration of N_PORT masters onto one
// single-port word memory, with one-cycle response latency and out-of-window error reporting.
module tcdm_mp_responder #(
  parameter int unsigned N_PORT    = 4,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1C01_0000,
  parameter logic [31:0] ERR_RDATA = 32'hBADA_CCE5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_PORT-1:0]     tcdm_req_i,
  output logic [N_PORT-1:0]     tcdm_gnt_o,
  input  logic [N_PORT*32-1:0]  tcdm_add_i,
  input  logic [N_PORT-1:0]     tcdm_wen_i,
  input  logic [N_PORT*4-1:0]   tcdm_be_i,
  input  logic [N_PORT*32-1:0]  tcdm_wdata_i,
  output logic [N_PORT*32-1:0]  tcdm_r_rdata_o,
  output logic [N_PORT-1:0]     tcdm_r_valid_o,
  output logic                  err_o,
  output logic [15:0]           err_cnt_o
);

  localparam int unsigned RR_W      = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);

  logic [31:0]     mem [MEM_WORDS];
  logic [RR_W-1:0] rr_q;
  logic [RR_W-1:0] sel;
  logic [RR_W-1:0] idx;
  logic            found;
  logic            go;
  logic [31:0]     add_sel;
  logic [31:0]     off;
  logic            in_win;
  logic [AW-1:0]   word;
  logic            is_write;
  logic [3:0]      be_sel;
  logic [31:0]     wdata_sel;
  logic [31:0]     resp_data;
  logic            unused_off_bits;

  // Rotating priority: first requester at or above rr_q, wrapping modulo N_PORT.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    idx   = '0;
    for (int unsigned i = 0; i < N_PORT; i++) begin
      idx = RR_W'((32'(rr_q) + i) % N_PORT);
      if (!found && tcdm_req_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign go = found && rst_ni;

  always_comb begin
    tcdm_gnt_o = '0;
    if (go) tcdm_gnt_o[sel] = 1'b1;
  end

  assign add_sel   = tcdm_add_i[32*sel +: 32];
  assign off       = add_sel - BASE_ADDR;
  assign in_win    = (add_sel >= BASE_ADDR) && (off < WIN_BYTES);
  assign word      = off[AW+1:2];
  assign is_write  = !tcdm_wen_i[sel];
  assign be_sel    = tcdm_be_i[4*sel +: 4];
  assign wdata_sel = tcdm_wdata_i[32*sel +: 32];

  assign unused_off_bits = ^{off[1:0], off[31:AW+2]};

  always_ff @(posedge clk_i) begin
    if (go && in_win && is_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_sel[b]) mem[word][8*b +: 8] <= wdata_sel[8*b +: 8];
      end
    end
  end

  // Read is taken from the array before this edge's write lands.
  always_comb begin
    resp_data = mem[word];
    if (!in_win)       resp_data = ERR_RDATA;
    else if (is_write) resp_data = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q           <= '0;
      tcdm_r_valid_o <= '0;
      tcdm_r_rdata_o <= '0;
      err_o          <= 1'b0;
      err_cnt_o      <= '0;
    end else begin
      tcdm_r_valid_o <= tcdm_gnt_o;
      err_o          <= go && !in_win;
      if (go) begin
        rr_q <= (sel == RR_W'(N_PORT - 1)) ? '0 : sel + 1'b1;
        tcdm_r_rdata_o[32*sel +: 32] <= resp_data;
        if (!in_win && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_mp_responder.sv
// Scoreboard bench for tcdm_mp_responder: stimulus pushes expected responses from a
// word-array reference model; a separate monitor pops and compares on each response.
module tb_tcdm_mp_responder;

  localparam int          NP   = 4;
  localparam int          MW   = 1024;
  localparam logic [31:0] BASE = 32'h1C01_0000;
  localparam logic [31:0] ERRD = 32'hBADA_CCE5;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   req;
  logic [NP-1:0]   gnt;
  logic [NP*32-1:0] add;
  logic [NP-1:0]   wen;
  logic [NP*4-1:0] be;
  logic [NP*32-1:0] wdata;
  logic [NP*32-1:0] rdata;
  logic [NP-1:0]   valid;
  logic            err;
  logic [15:0]     err_cnt;

  tcdm_mp_responder #(
    .N_PORT(NP), .MEM_WORDS(MW), .BASE_ADDR(BASE), .ERR_RDATA(ERRD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_wdata_i(wdata), .tcdm_r_rdata_o(rdata),
    .tcdm_r_valid_o(valid), .err_o(err), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [31:0] mask;
    bit          err;
    logic [15:0] cnt;
    int          due;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] mem_m   [MW];
  logic [3:0]  known_m [MW];
  int          rr_m;
  int          err_m;
  int          wait_m [NP];
  logic [NP-1:0] last_gnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input int p, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[p]          = 1'b1;
    wen[p]          = w;
    add[p*32 +: 32] = a;
    be[p*4 +: 4]    = b;
    wdata[p*32 +: 32] = d;
  endtask

  // One clock: predict and check the grant, update the model, push the expected response.
  task automatic step();
    logic [NP-1:0] exp_g;
    logic [31:0]   a, off, d, m;
    int            p, w;
    resp_t         it;
    @(negedge clk);
    exp_g = '0;
    p = -1;
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        int q = (rr_m + i) % NP;
        if (p < 0 && req[q]) p = q;
      end
    end
    if (p >= 0) exp_g[p] = 1'b1;
    last_gnt = gnt;
    chk("gnt", 32'(gnt), 32'(exp_g));
    for (int i = 0; i < NP; i++) begin
      if (rst_n && req[i]) begin
        if (i == p) begin
          chk("starvation_bound", 32'(wait_m[i] < NP), 32'd1);
          wait_m[i] = 0;
        end else wait_m[i]++;
      end
    end
    if (p >= 0) begin
      a   = add[p*32 +: 32];
      off = a - BASE;
      m   = '1;
      if (a >= BASE && off < 32'(4 * MW)) begin
        w = int'(off / 4);
        if (!wen[p]) begin
          d = '0;
          for (int b = 0; b < 4; b++) begin
            if (be[p*4 + b]) begin
              mem_m[w][8*b +: 8] = wdata[p*32 + 8*b +: 8];
              known_m[w][b] = 1'b1;
            end
          end
        end else begin
          d = mem_m[w];
          m = {{8{known_m[w][3]}}, {8{known_m[w][2]}}, {8{known_m[w][1]}}, {8{known_m[w][0]}}};
        end
        it.err = 1'b0;
      end else begin
        d = ERRD;
        it.err = 1'b1;
        if (err_m < 65535) err_m++;
      end
      it.port = p;
      it.data = d;
      it.mask = m;
      it.cnt  = 16'(err_m);
      it.due  = cyc + 1;
      sb.push_back(it);
      rr_m = (p + 1) % NP;
    end
    @(posedge clk);
    #1;
    if (p >= 0) req[p] = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    rr_m  = 0;
    err_m = 0;
    for (int i = 0; i < NP; i++) wait_m[i] = 0;
  endtask

  // Response monitor, decoupled from stimulus.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (|valid) begin
        if (sb.size() == 0) chk("spurious_valid", 32'(valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          chk("resp_valid", 32'(valid), 32'(1) << e.port);
          chk("resp_rdata", rdata[e.port*32 +: 32] & e.mask, e.data & e.mask);
          chk("resp_err", 32'(err), 32'(e.err));
          chk("resp_err_cnt", 32'(err_cnt), 32'(e.cnt));
        end
      end else begin
        chk("err_idle", 32'(err), 32'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("resp_missing", 32'(valid), 32'(1) << sb[0].port);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MW; i++) known_m[i] = 4'h0;
    rst_n = 1'b0;
    req = '0; add = '0; wen = '1; be = '0; wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    req = '1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < NP; i++) chk("rst_rdata", rdata[i*32 +: 32], 32'd0);
    step();

    // Contention from reset: grants rotate 0,1,2,3,...
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NP; p++) drive(p, 1'b1, BASE + 32'(4 * p), 4'h0, 32'h0);
      step();
      chk("rr_order", 32'(last_gnt), 32'(1) << (i % NP));
      chk("rr_resp_port", 32'(valid), 32'(1) << (i % NP));
    end
    req = '0;

    // Single port write then read.
    drive(0, 1'b0, BASE + 32'h10, 4'hF, 32'hA5A5_1234);
    step();
    chk("wr_valid", 32'(valid), 32'd1);
    chk("wr_rdata", rdata[31:0], 32'h0);
    drive(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    step();
    chk("rd_rdata", rdata[31:0], 32'hA5A5_1234);

    // Byte enables.
    drive(3, 1'b0, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
    step();
    drive(3, 1'b0, BASE + 32'h20, 4'b0101, 32'h0000_0000);
    step();
    drive(3, 1'b1, BASE + 32'h20, 4'h0, 32'h0);
    step();
    chk("be_rdata", rdata[3*32 +: 32], 32'hFF00_FF00);
    drive(3, 1'b0, BASE + 32'h20, 4'h0, 32'h1234_5678);
    step();
    drive(3, 1'b1, BASE + 32'h20, 4'h0, 32'h0);
    step();
    chk("be0_rdata", rdata[3*32 +: 32], 32'hFF00_FF00);

    // Out of window: top edge, just below base, and an aliasing write.
    drive(1, 1'b1, BASE + 32'(4 * MW), 4'h0, 32'h0);
    step();
    chk("oow_hi_rdata", rdata[32 +: 32], ERRD);
    drive(1, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
    step();
    chk("oow_lo_rdata", rdata[32 +: 32], ERRD);
    chk("oow_err_cnt", 32'(err_cnt), 32'd2);
    drive(1, 1'b0, BASE - 32'(4 * MW) + 32'h10, 4'hF, 32'hDEAD_BEEF);
    step();
    drive(1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    step();
    chk("oow_mem_intact", rdata[32 +: 32], 32'hA5A5_1234);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req[p] && $urandom_range(0, 1) == 1) begin
          logic [31:0] a;
          if ($urandom_range(0, 15) == 0)
            a = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 7))
                                             : BASE - 32'(4 * $urandom_range(1, 4));
          else
            a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
          drive(p, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
      end
      step();
    end
    for (int n = 0; n < 2 * NP && req != '0; n++) step();
    chk("drain_req", 32'(req), 32'd0);

    // Reset in the cycle after a read grant.
    drive(2, 1'b0, BASE + 32'h40, 4'hF, 32'h600D_F00D);
    step();
    drive(2, 1'b1, BASE + 32'h40, 4'h0, 32'h0);
    step();
    rst_n = 1'b0;
    model_reset();
    req = 4'b0011;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_rdata", rdata[2*32 +: 32], 32'd0);
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, BASE + 32'h40, 4'h0, 32'h0);
    for (int p = 1; p < NP; p++) drive(p, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    step();
    chk("post_rst_first_gnt", 32'(last_gnt), 32'd1);
    chk("post_rst_rdata", rdata[31:0], 32'h600D_F00D);
    for (int n = 0; n < NP && req != '0; n++) step();

    // Error counter saturation.
    for (int n = 0; n < 65537; n++) begin
      drive(1, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
      step();
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'h0000_FFFF);

    req = '0;
    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
